mcnc_bench_io_shell: RTL and testbench
======================================

Name: mcnc_bench_io_shell

Overview:
- I/O-limited harness that feeds a wide combinational benchmark (default 85 PIs / 66 POs) over narrow streaming links.
- Deserializes an input frame into the benchmark's primary-input vector and applies it atomically.
- Waits a settle interval, captures the primary-output vector and serializes it back out.
- Sits between the FPGA pad ring and the benchmark netlist; it is the opposite end of the benchmark's parallel PI/PO interface.

Parameters:
- PI_W, 85, benchmark primary-input count
- PO_W, 66, benchmark primary-output count
- LANE_W, 8, serial beat width, both directions
- SETTLE_CYC, 2, cycles between PI apply and PO capture, ≥1

Ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  input beat valid
- s_ready  out  1  shell accepts input beat
- s_data  in  LANE_W  input beat payload
- s_last  in  1  marks final beat of input frame
- pi_vec  out  PI_W  drives benchmark PIs
- po_vec  in  PO_W  benchmark POs
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts output beat
- m_data  out  LANE_W  output beat payload
- m_last  out  1  final beat of output frame
- frame_err  out  1  one-cycle pulse on framing violation
- busy  out  1  high in SETTLE or SEND

Behaviour:
- N_IN = ceil(PI_W/LANE_W), default 11. N_OUT = ceil(PO_W/LANE_W), default 9.
- Reset values: all outputs 0, state LOAD, beat counters 0, shadow/capture registers 0, pi_vec 0. Because state resets to LOAD, s_ready rises in the first cycle after reset deasserts.
- A beat transfers when valid & ready in the same cycle. A source may hold valid indefinitely. m_data, m_last and m_valid stay stable while m_valid & !m_ready.
- LOAD state:
  - s_ready=1.
  - Beat k is written to shadow bits [k*LANE_W +: LANE_W], LSB-first. Bits ≥PI_W in the last beat are discarded.
  - Beat N_IN-1 with s_last=1: pi_vec <= shadow (all PI_W bits updated in one cycle), counter <= 0, go to SETTLE. pi_vec never shows a partial frame.
  - s_last=1 on beat k<N_IN-1, or s_last=0 on beat N_IN-1: frame_err pulses the next cycle, the partial frame is dropped, counter <= 0, stay in LOAD. pi_vec is unchanged.
- SETTLE state:
  - s_ready=0.
  - Count SETTLE_CYC cycles, starting the cycle pi_vec holds the new value.
  - On the last count cycle: capture register <= po_vec, go to SEND.
- SEND state:
  - m_valid=1. m_data = capture bits [j*LANE_W +: LANE_W]; bits ≥PO_W read as 0.
  - m_last=1 iff j=N_OUT-1.
  - j advances on each transfer. The transfer with m_last returns to LOAD with m_valid=0 in the next cycle.
- Latency:
  - Final input beat accepted at edge t → pi_vec valid after t.
  - PO capture at edge t+SETTLE_CYC.
  - First m_valid in the cycle after that edge. With m_ready held high, the next s_ready follows N_OUT cycles later.
- No overlap: input is back-pressured (s_ready=0) throughout SETTLE and SEND.
- busy = (state != LOAD).
- Asynchronous rst in any state: immediate return to reset values. Any frame in flight is discarded and pi_vec=0.
- Counter widths: $clog2 of N_IN, N_OUT and SETTLE_CYC+1, minimum 1 bit. There are no wrap paths, since every counter is cleared on exit.

Decomposition:
- Package mcnc_shell_pkg:
  - state enum {LOAD, SETTLE, SEND}
  - constant functions for N_IN and N_OUT
  - constant function for counter-width helper
- One natural sub-module, lane_serializer: capture register, beat index and m_* handshake. It is reusable by other benchmark shells.
- Deserializer and FSM stay in the top.

Test Plan:
- Reset then frame: 11 beats 0x01..0x0B, s_last on beat 11, continuous valid. Required: pi_vec[7:0]=0x01, pi_vec[84:80]=0x0B&0x1F; pi_vec changes in exactly one cycle.
- Loopback check: tie po_vec=pi_vec[65:0] and send the same frame. Required: 9 output beats 0x01..0x08 then 0x09&0x03; m_last only on beat 9; first m_valid exactly SETTLE_CYC+1 cycles after the last input edge.
- Framing error: s_last on beat 5. Required: frame_err one-cycle pulse, pi_vec stays at its previous value, and a following good frame is accepted.
- Back-pressure: m_ready toggles 1,0,0,1… during SEND. Required: m_data/m_last stable while stalled, all 9 beats delivered in order, s_ready=0 until the final output transfer.
- Input gaps: s_valid deasserted for 3 cycles between beats 4 and 5. Required: same pi_vec as with no gaps, no frame_err.
- Mid-operation reset: assert rst during SEND beat 3. Required: m_valid=0, pi_vec=0 and s_ready=1 after release, then a fresh frame processes normally.

Source files
------------

// File: rtl/mcnc_shell_pkg.sv
// Shared types and sizing helpers for the benchmark I/O shells.
// Beat counts and counter widths are derived from the vector and lane widths.
package mcnc_shell_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        SEND   = 2'd2
    } state_e;

    function automatic int n_beats(input int w, input int lane);
        return (w + lane - 1) / lane;
    endfunction

    // Width of a counter holding values 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lane_serializer.sv
// Captures a wide result vector and streams it out LSB-first in LANE_W beats
// with a valid/ready handshake; done marks the transfer of the final beat.
module lane_serializer
    import mcnc_shell_pkg::*;
#(
    parameter int DATA_W = 66,
    parameter int LANE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [LANE_W-1:0] m_data,
    output logic              m_last,
    output logic              done
);

    localparam int N     = n_beats(DATA_W, LANE_W);
    localparam int IW    = cnt_w(N);
    localparam int PAD_W = N * LANE_W;

    logic [DATA_W-1:0]          cap_q, cap_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic                       act_q, act_d;
    logic [N-1:0][LANE_W-1:0]   cap_beats;
    logic                       xfer;

    // Zero-extension makes bits past DATA_W in the final beat read as 0.
    assign cap_beats = PAD_W'(cap_q);
    assign m_valid   = act_q;
    assign m_data    = cap_beats[idx_q];
    assign m_last    = act_q && (idx_q == IW'(N - 1));
    assign xfer      = act_q && m_ready;
    assign done      = xfer && m_last;

    always_comb begin
        cap_d = cap_q;
        idx_d = idx_q;
        act_d = act_q;
        if (load) begin
            cap_d = din;
            idx_d = '0;
            act_d = 1'b1;
        end else if (xfer) begin
            if (m_last) begin
                idx_d = '0;
                act_d = 1'b0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q <= '0;
            idx_q <= '0;
            act_q <= 1'b0;
        end else begin
            cap_q <= cap_d;
            idx_q <= idx_d;
            act_q <= act_d;
        end
    end

endmodule

// File: rtl/mcnc_bench_io_shell.sv
// Streaming harness around a wide combinational benchmark: deserialize a PI
// frame, apply it atomically, wait SETTLE_CYC cycles, serialize the POs back.
module mcnc_bench_io_shell
    import mcnc_shell_pkg::*;
#(
    parameter int PI_W       = 85,
    parameter int PO_W       = 66,
    parameter int LANE_W     = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [LANE_W-1:0] s_data,
    input  logic              s_last,
    output logic [PI_W-1:0]   pi_vec,
    input  logic [PO_W-1:0]   po_vec,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [LANE_W-1:0] m_data,
    output logic              m_last,
    output logic              frame_err,
    output logic              busy
);

    localparam int N_IN   = n_beats(PI_W, LANE_W);
    localparam int IN_CW  = cnt_w(N_IN);
    localparam int SET_CW = cnt_w(SETTLE_CYC + 1);

    state_e            state_q, state_d;
    logic [IN_CW-1:0]  in_cnt_q, in_cnt_d;
    logic [SET_CW-1:0] set_cnt_q, set_cnt_d;
    logic [PI_W-1:0]   shadow_q, shadow_d, shadow_nx;
    logic [PI_W-1:0]   pi_q, pi_d;
    logic              err_q, err_d;
    logic              cap_en, ser_done, last_beat;

    // Shadow with the current beat merged in; bits past PI_W simply have no slot.
    for (genvar b = 0; b < PI_W; b++) begin : g_shadow
        assign shadow_nx[b] = (in_cnt_q == IN_CW'(b / LANE_W)) ? s_data[b % LANE_W]
                                                                : shadow_q[b];
    end

    assign last_beat = (in_cnt_q == IN_CW'(N_IN - 1));
    assign s_ready   = (state_q == LOAD) && !rst;
    assign busy      = (state_q != LOAD);
    assign pi_vec    = pi_q;
    assign frame_err = err_q;

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        set_cnt_d = set_cnt_q;
        shadow_d  = shadow_q;
        pi_d      = pi_q;
        err_d     = 1'b0;
        cap_en    = 1'b0;
        case (state_q)
            LOAD: begin
                if (s_valid) begin
                    shadow_d = shadow_nx;
                    if (s_last && last_beat) begin
                        pi_d      = shadow_nx;
                        in_cnt_d  = '0;
                        set_cnt_d = '0;
                        state_d   = SETTLE;
                    end else if (s_last || last_beat) begin
                        err_d    = 1'b1;
                        in_cnt_d = '0;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (set_cnt_q == SET_CW'(SETTLE_CYC - 1)) begin
                    cap_en    = 1'b1;
                    set_cnt_d = '0;
                    state_d   = SEND;
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            SEND: begin
                if (ser_done) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LOAD;
            in_cnt_q  <= '0;
            set_cnt_q <= '0;
            shadow_q  <= '0;
            pi_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            set_cnt_q <= set_cnt_d;
            shadow_q  <= shadow_d;
            pi_q      <= pi_d;
            err_q     <= err_d;
        end
    end

    lane_serializer #(
        .DATA_W (PO_W),
        .LANE_W (LANE_W)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (cap_en),
        .din     (po_vec),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .done    (ser_done)
    );

endmodule

// File: tb/tb_mcnc_bench_io_shell.sv
// Directed bench for mcnc_bench_io_shell with the benchmark looped back
// (po_vec = pi_vec[65:0]): frame table plus hand-written reset sequences.
module tb_mcnc_bench_io_shell;

    localparam int PI_W       = 85;
    localparam int PO_W       = 66;
    localparam int LANE_W     = 8;
    localparam int SETTLE_CYC = 2;
    localparam int N_IN       = 11;
    localparam int N_OUT      = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [LANE_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic [PI_W-1:0]   pi_vec;
    logic [PO_W-1:0]   po_vec;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [LANE_W-1:0] m_data;
    logic              m_last;
    logic              frame_err;
    logic              busy;

    assign po_vec = pi_vec[PO_W-1:0];

    mcnc_bench_io_shell #(
        .PI_W       (PI_W),
        .PO_W       (PO_W),
        .LANE_W     (LANE_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .pi_vec    (pi_vec),
        .po_vec    (po_vec),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0][7:0] b;          // byte k = beat k
        int               last_pos;   // beat carrying s_last, -1 for none
        int               gap_after;  // 3 idle cycles after this beat, -1 for none
        bit               bp;         // m_ready pattern 1,0,0 repeating
        bit               exp_err;
        logic [PI_W-1:0]  exp_pi;
    } vec_t;

    vec_t vecs [6];
    int   checks   = 0;
    int   failures = 0;
    int   err_seen = 0;

    always @(negedge clk) if (frame_err) err_seen++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v, input bit stop_at_send);
        int nb, n, cyc, j, err0;
        bit stable, sr_ok;
        logic [PI_W-1:0]   prev_pi;
        logic [LANE_W-1:0] hold_d;
        logic              hold_l;
        logic [PO_W-1:0]   po;
        nb     = (v.last_pos >= 0) ? v.last_pos + 1 : N_IN;
        prev_pi = pi_vec;
        stable = 1'b1;
        err0   = err_seen;
        for (int k = 0; k < nb; k++) begin
            s_valid = 1'b1;
            s_data  = v.b[k];
            s_last  = (k == v.last_pos);
            n = 0;
            while (!s_ready && n < 100) begin tick(); n++; end
            if (n >= 100) chk("s_ready_timeout", 0, 1);
            tick();
            if (k < nb - 1 && pi_vec !== prev_pi) stable = 1'b0;
            if (k == v.gap_after) begin
                s_valid = 1'b0;
                repeat (3) begin
                    tick();
                    if (pi_vec !== prev_pi) stable = 1'b0;
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("pi_no_partial", stable, 1);
        chk("pi_vec", pi_vec, v.exp_pi);
        if (v.exp_err) begin
            chk("frame_err_pulse", frame_err, 1);
            tick();
            chk("frame_err_clear", frame_err, 0);
            chk("err_count", err_seen - err0, 1);
            chk("ready_after_err", s_ready, 1);
            return;
        end
        chk("busy_settle", busy, 1);
        cyc = 0;
        while (!m_valid && cyc < 50) begin tick(); cyc++; end
        chk("first_valid_latency", cyc, SETTLE_CYC);
        if (stop_at_send) return;
        po    = v.exp_pi[PO_W-1:0];
        j     = 0;
        cyc   = 0;
        sr_ok = 1'b1;
        while (j < N_OUT && cyc < 200) begin
            m_ready = v.bp ? (cyc % 3 == 0) : 1'b1;
            if (s_ready) sr_ok = 1'b0;
            if (!m_valid) chk("m_valid_in_send", m_valid, 1);
            if (m_ready) begin
                chk("m_data", m_data, LANE_W'(po >> (LANE_W * j)));
                chk("m_last", m_last, (j == N_OUT - 1));
                j++;
                tick();
            end else begin
                hold_d = m_data;
                hold_l = m_last;
                tick();
                chk("stall_stable", {m_valid, m_last, m_data}, {1'b1, hold_l, hold_d});
            end
            cyc++;
        end
        m_ready = 1'b0;
        chk("beats_delivered", j, N_OUT);
        chk("s_ready_low_in_send", sr_ok, 1);
        if (!v.bp) chk("send_cycles", cyc, N_OUT);
        chk("m_valid_after_last", m_valid, 0);
        chk("s_ready_after_last", s_ready, 1);
        chk("busy_after_last", busy, 0);
        chk("no_err_good_frame", err_seen - err0, 0);
    endtask

    initial begin
        logic [10:0][7:0] inc, ones, alt;
        logic [PI_W-1:0]  p_inc, p_alt;
        for (int k = 0; k < N_IN; k++) begin
            inc[k]  = 8'(k + 1);
            ones[k] = 8'hFF;
            alt[k]  = (k % 2 == 0) ? 8'hA5 : 8'h5A;
        end
        p_inc = 85'h0B0A090807060504030201;
        p_alt = 85'h055AA55AA55AA55AA55AA5;
        vecs[0] = '{b: inc,  last_pos: 10, gap_after: -1, bp: 0, exp_err: 0, exp_pi: p_inc};
        vecs[1] = '{b: inc,  last_pos: 4,  gap_after: -1, bp: 0, exp_err: 1, exp_pi: p_inc};
        vecs[2] = '{b: ones, last_pos: 10, gap_after: -1, bp: 1, exp_err: 0, exp_pi: {PI_W{1'b1}}};
        vecs[3] = '{b: alt,  last_pos: -1, gap_after: -1, bp: 0, exp_err: 1, exp_pi: {PI_W{1'b1}}};
        vecs[4] = '{b: alt,  last_pos: 10, gap_after: -1, bp: 1, exp_err: 0, exp_pi: p_alt};
        vecs[5] = '{b: inc,  last_pos: 10, gap_after: 3,  bp: 0, exp_err: 0, exp_pi: p_inc};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {s_ready, m_valid, m_last, m_data, frame_err, busy}, '0);
        chk("rst_pi_vec", pi_vec, 0);
        #3 rst = 1'b0;
        #1;
        chk("s_ready_after_rst", s_ready, 1);
        tick();

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], 1'b0);
            tick();
        end

        // Reset while the third output beat is on the bus.
        run_frame(vecs[0], 1'b1);
        m_ready = 1'b1;
        tick();
        tick();
        m_ready = 1'b0;
        chk("send_beat3", {m_valid, m_data}, {1'b1, 8'h03});
        #2 rst = 1'b1;
        #1;
        chk("midrst_outputs", {m_valid, s_ready, busy}, '0);
        chk("midrst_pi_vec", pi_vec, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_release", {s_ready, m_valid, busy}, 3'b100);
        tick();
        run_frame(vecs[2], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
